// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_ctrl
// Purpose  : Load/store sequencer between MEM stage and word-only data memory;
//            sub-word stores use read-modify-write, sub-word loads extract+extend.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_memwr,
    output logic        dm_memread,
    input  logic [31:0] dm_rdata,
    input  logic        dm_exp
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_WCHK  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [1:0] c_EXC_NONE = 2'b00;
    localparam logic [1:0] c_EXC_ALE  = 2'b01;
    localparam logic [1:0] c_EXC_ADE  = 2'b10;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_exc;

    logic        w_ale;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merge;

    // Size 3 is treated as word, so bit 1 alone marks a word access.
    assign w_ale = ((req_size == 2'd1) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_byte     = dm_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half     = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        w_load_ext = dm_rdata;
        w_merge    = dm_rdata;
        case (r_size)
            2'd0: begin
                w_load_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
                w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            2'd1: begin
                w_load_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
                w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_load_ext = dm_rdata;
                w_merge    = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_exc      <= c_EXC_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rdata    <= 32'd0;
                        if (w_ale) begin
                            r_exc   <= c_EXC_ALE;
                            r_state <= S_RESP;
                        end else begin
                            r_exc   <= c_EXC_NONE;
                            r_state <= (req_we && req_size[1]) ? S_WRITE : S_READ;
                        end
                    end
                end
                S_READ:  r_state <= S_WAIT;
                S_WAIT: begin
                    if (dm_exp) begin
                        r_exc   <= c_EXC_ADE;
                        r_state <= S_RESP;
                    end else if (!r_we) begin
                        r_rdata <= w_load_ext;
                        r_state <= S_RESP;
                    end else begin
                        r_wdata <= w_merge;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: r_state <= S_WCHK;
                S_WCHK: begin
                    if (dm_exp) begin
                        r_exc <= c_EXC_ADE;
                    end
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign dm_memread = (r_state == S_READ);
    assign dm_memwr   = (r_state == S_WRITE);
    assign resp_rdata = r_rdata;
    assign resp_exc   = r_exc;
    assign dm_addr    = {r_addr[31:2], 2'b00};
    assign dm_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_ctrl
// Purpose  : Directed self-checking bench for dm_access_ctrl with a 16 KB
//            word memory model that flags out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_memwr;
    logic        dm_memread;
    logic [31:0] dm_rdata;
    logic        dm_exp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:4095];

    dm_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_exc     (resp_exc),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_memwr     (dm_memwr),
        .dm_memread   (dm_memread),
        .dm_rdata     (dm_rdata),
        .dm_exp       (dm_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data and range flag appear the cycle after the access.
    always @(posedge clk) begin
        dm_exp <= 1'b0;
        if (dm_memread) begin
            dm_exp   <= (dm_addr >= 32'h4000);
            dm_rdata <= (dm_addr < 32'h4000) ? mem[dm_addr[13:2]] : 32'h0BAD_0BAD;
        end
        if (dm_memwr) begin
            dm_exp <= (dm_addr >= 32'h4000);
            if (dm_addr < 32'h4000) mem[dm_addr[13:2]] <= dm_wdata;
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic [1:0] exc,
                          output int nrd, output int nwr, output int nboth);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 32'hFFFF_FFFF; exc = 2'b11; nrd = 0; nwr = 0; nboth = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (dm_memread) nrd++;
            if (dm_memwr) nwr++;
            if (dm_memread && dm_memwr) nboth++;
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; exc = resp_exc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({resp_valid, dm_memwr, dm_memread, resp_exc} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v=%b wr=%b rd=%b exc=%b expected all 0",
                     resp_valid, dm_memwr, dm_memread, resp_exc);
        end
        n_checks++;
        if ({resp_rdata, dm_addr, dm_wdata} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0",
                     resp_rdata, dm_addr, dm_wdata);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_word_roundtrip();
        int lat, nrd, nwr, nb;
        logic [31:0] rd;
        logic [1:0]  ex;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 3 || ex !== 2'b00 || nwr !== 1 || nrd !== 0) begin
            n_fail++;
            $display("FAIL st_w: got lat=%0d exc=%b rd=%0d wr=%0d expected lat=3 exc=00 rd=0 wr=1",
                     lat, ex, nrd, nwr);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 3 || rd !== 32'hDEAD_BEEF || ex !== 2'b00) begin
            n_fail++;
            $display("FAIL ld_w: got lat=%0d rdata=%h exc=%b expected lat=3 rdata=deadbeef exc=00",
                     lat, rd, ex);
        end
    endtask

    task automatic test_byte_rmw();
        int lat, nrd, nwr, nb;
        logic [31:0] rd;
        logic [1:0]  ex;
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, lat, rd, ex, nrd, nwr, nb);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 5 || nrd !== 1 || nwr !== 1 || nb !== 0 || ex !== 2'b00) begin
            n_fail++;
            $display("FAIL st_b_rmw: got lat=%0d rd=%0d wr=%0d both=%0d exc=%b expected lat=5 rd=1 wr=1 both=0 exc=00",
                     lat, nrd, nwr, nb, ex);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (rd !== 32'h11AA_3344) begin
            n_fail++;
            $display("FAIL st_b_merge: got %h expected 11aa3344", rd);
        end
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_5A5A, lat, rd, ex, nrd, nwr, nb);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (rd !== 32'h5A5A_3344) begin
            n_fail++;
            $display("FAIL st_h_merge: got %h expected 5a5a3344", rd);
        end
    endtask

    task automatic test_subword_loads();
        logic [31:0] addrs [5] = '{32'h30, 32'h33, 32'h33, 32'h32, 32'h32};
        logic [1:0]  sizes [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        logic        unss  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [5] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                                   32'hFFFF_8000, 32'h0000_8000};
        int lat, nrd, nwr, nb;
        logic [31:0] rd;
        logic [1:0]  ex;
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h8000_0001, lat, rd, ex, nrd, nwr, nb);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, ex, nrd, nwr, nb);
            n_checks++;
            if (rd !== exps[i] || lat !== 3) begin
                n_fail++;
                $display("FAIL subword_load[%0d]: got rdata=%h lat=%0d expected rdata=%h lat=3",
                         i, rd, lat, exps[i]);
            end
        end
    endtask

    task automatic test_misalign();
        int lat, nrd, nwr, nb;
        logic [31:0] rd;
        logic [1:0]  ex;
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 1 || ex !== 2'b01 || rd !== 32'd0 || nrd !== 0 || nwr !== 0) begin
            n_fail++;
            $display("FAIL ale_ld_w: got lat=%0d exc=%b rdata=%h rd=%0d wr=%0d expected 1 01 0 0 0",
                     lat, ex, rd, nrd, nwr);
        end
        do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'hBEEF, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 1 || ex !== 2'b01 || nrd !== 0 || nwr !== 0) begin
            n_fail++;
            $display("FAIL ale_st_h: got lat=%0d exc=%b rd=%0d wr=%0d expected 1 01 0 0",
                     lat, ex, nrd, nwr);
        end
        do_req(1'b0, 2'd3, 1'b0, 32'h21, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 1 || ex !== 2'b01) begin
            n_fail++;
            $display("FAIL ale_size3: got lat=%0d exc=%b expected 1 01", lat, ex);
        end
    endtask

    task automatic test_out_of_range();
        int lat, nrd, nwr, nb;
        logic [31:0] rd;
        logic [1:0]  ex;
        do_req(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 3 || ex !== 2'b10 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL ade_ld_w: got lat=%0d exc=%b rdata=%h expected 3 10 0", lat, ex, rd);
        end
        do_req(1'b1, 2'd0, 1'b0, 32'h4001, 32'h77, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 3 || ex !== 2'b10 || nwr !== 0 || nrd !== 1) begin
            n_fail++;
            $display("FAIL ade_st_b: got lat=%0d exc=%b rd=%0d wr=%0d expected 3 10 1 0",
                     lat, ex, nrd, nwr);
        end
        do_req(1'b1, 2'd2, 1'b0, 32'h4004, 32'h77, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 3 || ex !== 2'b10 || nwr !== 1) begin
            n_fail++;
            $display("FAIL ade_st_w: got lat=%0d exc=%b wr=%0d expected 3 10 1", lat, ex, nwr);
        end
    endtask

    task automatic test_reset_mid_store();
        int lat, nrd, nwr, nb;
        logic [31:0] rd;
        logic [1:0]  ex;
        bit found, pulsed;
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, lat, rd, ex, nrd, nwr, nb);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h42; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dm_memwr) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_reach_write: got no dm_memwr expected one");
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dm_memwr !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got memwr=%b ready=%b expected 0 1", dm_memwr, req_ready);
        end
        pulsed = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) pulsed = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid) pulsed = 1'b1;
        end
        n_checks++;
        if (pulsed) begin
            n_fail++;
            $display("FAIL rst_mid_no_resp: got resp_valid pulse expected none");
        end
        n_checks++;
        if (req_ready !== 1'b1 || mem[16] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rst_mid_mem: got ready=%b mem=%h expected 1 cafef00d", req_ready, mem[16]);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, rd, ex, nrd, nwr, nb);
        n_checks++;
        if (lat !== 3 || rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rst_mid_readback: got lat=%0d rdata=%h expected 3 cafef00d", lat, rd);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rst_n = 1'b0;
        test_reset();
        test_word_roundtrip();
        test_byte_rmw();
        test_subword_loads();
        test_misalign();
        test_out_of_range();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
